// File: rtl/dmem_resp_pkg.sv
// dmem_responder shared definitions.
// FSM encoding, MMIO address and LATENCY limits.
package dmem_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  // Top word of the default 10-bit space.
  localparam logic [9:0] MMIO_ADDR = 10'h3FF;

  function automatic int lat_clamp(input int l);
    if (l < LAT_MIN) return LAT_MIN;
    if (l > LAT_MAX) return LAT_MAX;
    return l;
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// dmem_responder storage: 32-bit array, sync write, sync read.
// Read register holds its value until the next read enable.
module dmem_resp_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with CPU stall output.
// Optional cycle-counter MMIO word: define DMEM_RESP_MMIO_EN.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  input  logic              rden,
  input  logic              wren,
  output logic [31:0]       q,
  output logic              stall,
  output logic              proto_err
);

  localparam int         LAT    = lat_clamp(LATENCY);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              wr_q;
  logic              perr_q, perr_d;

  logic              req, is_idle, is_busy;
  logic              accept, go, op_flip;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic              acc_wr, mmio_hit;
  logic              ram_we, ram_re;
  logic [31:0]       ram_q;

  assign req     = rden | wren;
  assign is_idle = (state_q == ST_IDLE);
  assign is_busy = (state_q == ST_BUSY);
  assign accept  = is_idle & req;

  // LATENCY=1 performs the access on the accepting edge itself.
  assign go = (accept & (LAT == 1))
            | (is_busy & req & (cnt_q == 4'd1));

  assign op_flip = is_busy
                 & (wr_q ? (rden & ~wren) : (wren & ~rden));

  assign acc_addr = is_idle ? address : addr_q;
  assign acc_data = is_idle ? data : data_q;
  assign acc_wr   = is_idle ? wren : wr_q;

  assign stall     = accept | is_busy;
  assign proto_err = perr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = LAT_M1;
          state_d = (LAT == 1) ? ST_DONE : ST_BUSY;
          if (rden & wren) perr_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!req) begin
          state_d = ST_IDLE;
          perr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (op_flip) perr_d = 1'b1;
          if (cnt_q == 4'd1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go & acc_wr & mmio_hit) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      if (accept) begin
        addr_q <= address;
        data_q <= data;
        wr_q   <= wren;
      end
    end
  end

  assign ram_we = go & acc_wr & ~mmio_hit & ~rst;
  assign ram_re = go & ~acc_wr & ~mmio_hit;

  dmem_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (acc_addr),
    .wdata_i (acc_data),
    .rdata_o (ram_q)
  );

`ifdef DMEM_RESP_MMIO_EN
  localparam logic [ADDR_W-1:0] MMIO_A = '1;

  logic [31:0] cyc_q, snap_q;
  logic        sel_q;

  assign mmio_hit = (acc_addr == MMIO_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      snap_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (go & ~acc_wr) begin
        sel_q <= mmio_hit;
        if (mmio_hit) snap_q <= cyc_q;
      end
    end
  end

  assign q = sel_q ? snap_q : ram_q;
`else
  assign mmio_hit = 1'b0;
  assign q        = ram_q;
`endif

endmodule
